// File: rtl/osd_info_queue.sv
// OSD info queue: edge-detects producer info requests, coalesces repeats, buffers
// codes in a small FIFO and forwards them to hps_io with a minimum on-screen hold.
module osd_info_queue #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_TICKS = 16,
    parameter int TICK_BITS  = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          info_req,
    input  logic [7:0]                    info,
    output logic                          hps_info_req,
    output logic [7:0]                    hps_info,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   pending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLD_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [TICK_BITS-1:0] div_q, div_d;
    logic                 req_prev_q;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [7:0]           hps_info_q, hps_info_d;
    logic                 ovf_q, ovf_d;

    logic                 tick_s;
    logic                 accept_s;
    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 showing_s;
    logic [7:0]           tail_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 reload_s;
    logic                 pop_s;

    assign tick_s       = (div_q == {TICK_BITS{1'b0}});
    assign accept_s     = info_req & ~req_prev_q;
    assign fifo_empty_s = (count_q == {CNT_W{1'b0}});
    assign fifo_full_s  = (count_q == CNT_FULL);
    assign showing_s    = (state_q != ST_IDLE);
    // Newest entry sits one behind the write pointer; only meaningful when non-empty.
    assign tail_s       = mem_q[wr_ptr_q - PTR_W'(1)];
    assign pop_s        = (state_q == ST_IDLE) && !fifo_empty_s;

    // Accept filter: ignore zero, refresh the shown code, coalesce tail repeats, else push or drop.
    always_comb begin
        push_s   = 1'b0;
        drop_s   = 1'b0;
        reload_s = 1'b0;
        if (accept_s && (info != 8'd0)) begin
            if (showing_s && (info == hps_info_q)) begin
                reload_s = 1'b1;
            end else if (!fifo_empty_s && (info == tail_s)) begin
                push_s = 1'b0;
            end else if (fifo_full_s) begin
                drop_s = 1'b1;
            end else begin
                push_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: state_d = ST_HOLD;
            ST_HOLD: begin
                if (reload_s) begin
                    state_d = ST_HOLD;
                end else if (timer_q == {TMR_W{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next-state: hold timer, shown code, FIFO bookkeeping, divider.
    always_comb begin
        timer_d = timer_q;
        case (state_q)
            ST_SEND: timer_d = TMR_LOAD;
            ST_HOLD: begin
                if (reload_s) begin
                    timer_d = TMR_LOAD;
                end else if (tick_s && (timer_q != {TMR_W{1'b0}})) begin
                    timer_d = timer_q - TMR_W'(1);
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_IDLE: timer_d = timer_q;
            default: timer_d = {TMR_W{1'b0}};
        endcase

        if (pop_s) begin
            hps_info_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end else begin
            hps_info_d = hps_info_q;
            rd_ptr_d   = rd_ptr_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        ovf_d   = ovf_q | drop_s;
        div_d   = div_q - TICK_BITS'(1);
    end

    // State and datapath registers with synchronous reset; reset also flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_q      <= {TICK_BITS{1'b1}};
            req_prev_q <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            timer_q    <= {TMR_W{1'b0}};
            hps_info_q <= 8'd0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            req_prev_q <= info_req;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            timer_q    <= timer_d;
            hps_info_q <= hps_info_d;
            ovf_q      <= ovf_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= info;
            end
        end
    end

    assign hps_info_req = (state_q == ST_SEND);
    assign busy         = (state_q != ST_IDLE);
    assign hps_info     = hps_info_q;
    assign overflow     = ovf_q;
    assign pending      = count_q;

endmodule

// File: tb/tb_osd_info_queue.sv
// Bench for osd_info_queue: behavioural queue model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_osd_info_queue;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;
    localparam int TBITS = 4;
    localparam int TPER  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       info_req = 1'b0;
    logic [7:0] info = 8'd0;
    logic       hps_info_req;
    logic [7:0] hps_info;
    logic       busy;
    logic       overflow;
    logic [2:0] pending;

    osd_info_queue #(
        .FIFO_DEPTH(DEPTH),
        .HOLD_TICKS(HOLD),
        .TICK_BITS (TBITS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .info_req    (info_req),
        .info        (info),
        .hps_info_req(hps_info_req),
        .hps_info    (hps_info),
        .busy        (busy),
        .overflow    (overflow),
        .pending     (pending)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: a code list, the code on screen, and what the screen is doing.
    int m_q[$];
    int m_show = 0;
    int m_mode = 0;   // 0 nothing shown, 1 announcing, 2 holding
    int m_left = 0;
    int m_cyc  = 0;
    bit m_prev = 1'b0;
    bit m_ovf  = 1'b0;
    bit chk_en = 1'b0;
    int last_acc = 0;
    int pend_peak = 0;

    int pulse_log[$];
    int pulse_cyc[$];

    task automatic model_step();
        bit tick;
        bit acc;
        bit push;
        bit reload;
        int code;
        tick   = ((m_cyc % TPER) == TPER - 1);
        acc    = info_req && !m_prev;
        code   = int'(info);
        push   = 1'b0;
        reload = 1'b0;
        if (acc && code != 0) begin
            if (m_mode != 0 && code == m_show) reload = 1'b1;
            else if (m_q.size() > 0 && code == m_q[$]) push = 1'b0;
            else if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else push = 1'b1;
        end
        if (m_mode == 0) begin
            if (m_q.size() > 0) begin
                m_show = m_q.pop_front();
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
            m_left = HOLD;
        end else begin
            if (reload) m_left = HOLD;
            else if (m_left == 0) m_mode = 0;
            else if (tick) m_left = m_left - 1;
        end
        if (push) m_q.push_back(code);
        m_prev = info_req;
        m_cyc  = m_cyc + 1;
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_q.delete();
            m_show = 0;
            m_mode = 0;
            m_left = 0;
            m_cyc  = 0;
            m_prev = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            model_step();
        end
    end

    // Per-cycle comparison against the model, plus pulse logging.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("hps_info_req", hps_info_req, (m_mode == 1));
            check("busy", busy, (m_mode != 0));
            check("hps_info", hps_info, m_show);
            check("pending", pending, m_q.size());
            check("overflow", overflow, m_ovf);
            if (hps_info_req === 1'b1) begin
                pulse_log.push_back(int'(hps_info));
                pulse_cyc.push_back(m_cyc);
            end
            if (int'(pending) > pend_peak) pend_peak = int'(pending);
        end
    end

    function automatic int ticks_in(input int a, input int b);
        int n = 0;
        for (int k = a + 1; k < b; k++) begin
            if ((k % TPER) == TPER - 1) n++;
        end
        return n;
    endfunction

    task automatic edge_code(input int code);
        @(negedge clk);
        info     = 8'(code);
        info_req = 1'b1;
        last_acc = m_cyc;
        @(negedge clk);
        info_req = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int maxc, output int pc);
        pc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (hps_info_req === 1'b1) begin
                pc = m_cyc;
                break;
            end
        end
        if (pc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no pulse within %0d cycles", name, maxc);
        end
    endtask

    task automatic wait_drain(input string name, input int maxc, output int fc);
        fc = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && pending === 3'd0) begin
                fc = m_cyc;
                break;
            end
        end
        if (fc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: still busy after %0d cycles", name, maxc);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int f;
        int a;
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_req", hps_info_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_info", hps_info, 8'd0);
        check("rst_pending", pending, 3'd0);
        check("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single code from idle
        base = pulse_log.size();
        edge_code(5);
        a = last_acc;
        wait_pulse("t1_pulse", 10, p);
        check("t1_latency", p - a, 2);
        check("t1_code", hps_info, 8'd5);
        wait_drain("t1_idle", 200, f);
        check("t1_hold_ticks", ticks_in(p, f), HOLD);
        check("t1_pending", pending, 3'd0);
        check("t1_info_kept", hps_info, 8'd5);
        check("t1_npulse", pulse_log.size() - base, 1);

        // 2: three codes back to back
        repeat (3) @(negedge clk);
        pend_peak = 0;
        base = pulse_log.size();
        edge_code(3);
        edge_code(4);
        edge_code(6);
        wait_drain("t2_drain", 400, f);
        check("t2_npulse", pulse_log.size() - base, 3);
        check("t2_code0", pulse_log[base], 3);
        check("t2_code1", pulse_log[base + 1], 4);
        check("t2_code2", pulse_log[base + 2], 6);
        check("t2_gap01", (ticks_in(pulse_cyc[base], pulse_cyc[base + 1]) >= HOLD), 1'b1);
        check("t2_gap12", (ticks_in(pulse_cyc[base + 1], pulse_cyc[base + 2]) >= HOLD), 1'b1);
        check("t2_peak", pend_peak, 2);

        // 3: toggling request coalesces into one pulse
        repeat (3) @(negedge clk);
        base = pulse_log.size();
        a = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            info     = 8'd2;
            info_req = 1'b1;
            a        = m_cyc;
            @(negedge clk);
            info_req = 1'b0;
        end
        wait_drain("t3_drain", 200, f);
        check("t3_npulse", pulse_log.size() - base, 1);
        check("t3_code", pulse_log[base], 2);
        check("t3_hold_after_last", ticks_in(a, f), HOLD);

        // 4: burst overflows while busy on 9
        repeat (3) @(negedge clk);
        base = pulse_log.size();
        edge_code(9);
        wait_pulse("t4_pulse9", 10, p);
        for (int c = 1; c <= 6; c++) edge_code(c);
        check("t4_ovf", overflow, 1'b1);
        check("t4_pending", pending, 3'd4);
        wait_drain("t4_drain", 600, f);
        check("t4_npulse", pulse_log.size() - base, 5);
        check("t4_code9", pulse_log[base], 9);
        for (int c = 1; c <= 4; c++) check("t4_code", pulse_log[base + c], c);
        check("t4_ovf_sticky", overflow, 1'b1);

        // 5: zero code and tail duplicate are not queued
        repeat (3) @(negedge clk);
        edge_code(10);
        wait_pulse("t5_pulse10", 10, p);
        edge_code(7);
        edge_code(8);
        check("t5_pending_pre", pending, 3'd2);
        edge_code(8);
        edge_code(0);
        check("t5_pending_post", pending, 3'd2);
        check("t5_busy", busy, 1'b1);

        // 6: reset mid-hold flushes everything
        base = pulse_log.size();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", busy, 1'b0);
        check("t6_pending", pending, 3'd0);
        check("t6_ovf", overflow, 1'b0);
        check("t6_req", hps_info_req, 1'b0);
        check("t6_info", hps_info, 8'd0);
        repeat (100) @(negedge clk);
        check("t6_no_pulse", pulse_log.size() - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
